// File: rtl/lfsr_writer_pkg.sv
// Shared types and constants for the lfsr_writer stimulus block.
// The csum output is present only when LFSR_WRITER_CSUM_EN is defined.
package lfsr_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] DEF_TAPS = 8'hB8;
    localparam logic [7:0] DEF_SEED = 8'h01;
    localparam int         CSUM_W   = 16;

endpackage

// File: rtl/lfsr_writer_if.sv
// Control and FIFO-write bus between lfsr_writer and its consumer.
// The csum signal exists only when LFSR_WRITER_CSUM_EN is defined.
interface lfsr_writer_if
    import lfsr_writer_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 8,
    parameter int GWIDTH = 4
);
    logic              start;
    logic              abort;
    logic [CWIDTH-1:0] count;
    logic [GWIDTH-1:0] gap;
    logic              full;
    logic [DWIDTH-1:0] datain;
    logic              write;
    logic              busy;
    logic              done;
    logic [CWIDTH-1:0] sent;
`ifdef LFSR_WRITER_CSUM_EN
    logic [CSUM_W-1:0] csum;
`endif

    modport master (
        input  start, abort, count, gap, full,
        output datain, write, busy, done, sent
`ifdef LFSR_WRITER_CSUM_EN
        , output csum
`endif
    );

    modport slave (
        output start, abort, count, gap, full,
        input  datain, write, busy, done, sent
`ifdef LFSR_WRITER_CSUM_EN
        , input csum
`endif
    );

endinterface

// File: rtl/lfsr_writer_lfsr_core.sv
// Galois LFSR register: loads the seed on reset, steps one position per advance.
// A zero seed would lock the register, so it is replaced by 1.
module lfsr_core
    import lfsr_writer_pkg::*;
#(
    parameter int                DWIDTH = 8,
    parameter logic [DWIDTH-1:0] TAPS   = DEF_TAPS,
    parameter logic [DWIDTH-1:0] SEED   = DEF_SEED
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_advance,
    output logic [DWIDTH-1:0] o_lfsr
);

    localparam logic [DWIDTH-1:0] SEED_EFF = (SEED == '0) ? DWIDTH'(1) : SEED;

    logic [DWIDTH-1:0] r_lfsr;
    logic [DWIDTH-1:0] w_lfsr_next;

    // Shift right; the bit falling out of position 0 is folded back through the tap mask.
    genvar gi;
    generate
        for (gi = 0; gi < DWIDTH - 1; gi++) begin : g_shift
            assign w_lfsr_next[gi] = r_lfsr[gi+1] ^ (r_lfsr[0] & TAPS[gi]);
        end
    endgenerate
    assign w_lfsr_next[DWIDTH-1] = r_lfsr[0] & TAPS[DWIDTH-1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED_EFF;
        end else if (i_advance) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/lfsr_writer.sv
// Pseudo-random word source for a dual-clock FIFO write port, with counted bursts and idle gaps.
// Define LFSR_WRITER_CSUM_EN to add a 16-bit running checksum of accepted words.
module lfsr_writer
    import lfsr_writer_pkg::*;
#(
    parameter int                DWIDTH = 8,
    parameter logic [DWIDTH-1:0] TAPS   = DEF_TAPS,
    parameter logic [DWIDTH-1:0] SEED   = DEF_SEED,
    parameter int                CWIDTH = 8,
    parameter int                GWIDTH = 4
)(
    input  logic          wr_clk,
    input  logic          areset_n,
    lfsr_writer_if.master bus
);

    state_t            r_state;
    state_t            w_state_next;
    logic [CWIDTH-1:0] r_count;
    logic [GWIDTH-1:0] r_gap;
    logic [GWIDTH-1:0] r_gcnt;
    logic [CWIDTH-1:0] r_sent;
    logic [CWIDTH-1:0] w_sent_inc;
    logic              r_done;
    logic [DWIDTH-1:0] w_lfsr;
    logic              w_write;
    logic              w_busy;
    logic              w_run_start;
    logic              w_last;

    lfsr_core #(
        .DWIDTH (DWIDTH),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .i_clk     (wr_clk),
        .i_rst_n   (areset_n),
        .i_advance (w_write),
        .o_lfsr    (w_lfsr)
    );

    // abort beats start in IDLE, so a coincident pair never opens a run.
    assign w_run_start = (r_state == IDLE) && bus.start && !bus.abort;
    assign w_sent_inc  = r_sent + CWIDTH'(1);
    assign w_last      = (r_count != '0) && (w_sent_inc == r_count);

    always_ff @(posedge wr_clk) begin
        if (!areset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_run_start) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    w_state_next = IDLE;
                end else if (w_write) begin
                    if (w_last) begin
                        w_state_next = IDLE;
                    end else if (r_gap != '0) begin
                        w_state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (bus.abort) begin
                    w_state_next = IDLE;
                end else if (r_gcnt == GWIDTH'(1)) begin
                    w_state_next = SEND;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Acceptance is the strobe itself: the FIFO takes the word whenever write is high.
    always_comb begin
        w_write = 1'b0;
        w_busy  = 1'b0;
        if (r_state != IDLE) begin
            w_busy = 1'b1;
        end
        if ((r_state == SEND) && !bus.full && !bus.abort) begin
            w_write = 1'b1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (!areset_n) begin
            r_count <= '0;
            r_gap   <= '0;
            r_gcnt  <= '0;
            r_sent  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_run_start) begin
                r_count <= bus.count;
                r_gap   <= bus.gap;
                r_sent  <= '0;
            end
            if (w_write) begin
                r_sent <= w_sent_inc;
                if (w_last) begin
                    r_done <= 1'b1;
                end else if (r_gap != '0) begin
                    r_gcnt <= r_gap;
                end
            end
            if ((r_state == GAP) && !bus.abort) begin
                r_gcnt <= r_gcnt - GWIDTH'(1);
            end
        end
    end

`ifdef LFSR_WRITER_CSUM_EN
    logic [CSUM_W-1:0] r_csum;

    always_ff @(posedge wr_clk) begin
        if (!areset_n) begin
            r_csum <= '0;
        end else if (w_run_start) begin
            r_csum <= '0;
        end else if (w_write) begin
            r_csum <= r_csum + CSUM_W'(w_lfsr);
        end
    end

    assign bus.csum = r_csum;
`endif

    assign bus.datain = w_lfsr;
    assign bus.write  = w_write;
    assign bus.busy   = w_busy;
    assign bus.done   = r_done;
    assign bus.sent   = r_sent;

endmodule

// File: tb/tb_lfsr_writer.sv
// Directed bench for lfsr_writer: a per-cycle vector table for plain and gapped bursts,
// then hand-written stall, abort and mid-run reset sequences.
module tb_lfsr_writer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    lfsr_writer_if #(.DWIDTH(8), .CWIDTH(8), .GWIDTH(4)) bus ();

    lfsr_writer dut (
        .wr_clk   (clk),
        .areset_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       st;
        logic [7:0] cnt;
        logic [3:0] gp;
        logic       ew;
        logic [7:0] ed;
        logic       eb;
        logic       edn;
        logic [7:0] es;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [7:0] cnt, input logic [3:0] gp,
                                input logic ew, input logic [7:0] ed, input logic eb,
                                input logic edn, input logic [7:0] es);
        vec_t v;
        v.st = st; v.cnt = cnt; v.gp = gp;
        v.ew = ew; v.ed = ed; v.eb = eb; v.edn = edn; v.es = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int NV = 18;
    vec_t       tbl [NV];
    logic [7:0] seq [26];
    logic [7:0] acc [16];
    int         n_acc;
    int         stall;
    bit         stalled_once;
    bit         got_done;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        // Hand-stepped Galois sequence from seed 01 with taps B8.
        seq[0]  = 8'h01; seq[1]  = 8'hB8; seq[2]  = 8'h5C; seq[3]  = 8'h2E; seq[4]  = 8'h17;
        seq[5]  = 8'hB3; seq[6]  = 8'hE1; seq[7]  = 8'hC8; seq[8]  = 8'h64; seq[9]  = 8'h32;
        seq[10] = 8'h19; seq[11] = 8'hB4; seq[12] = 8'h5A; seq[13] = 8'h2D; seq[14] = 8'hAE;
        seq[15] = 8'h57; seq[16] = 8'h93; seq[17] = 8'hF1; seq[18] = 8'hC0; seq[19] = 8'h60;
        seq[20] = 8'h30; seq[21] = 8'h18; seq[22] = 8'h0C; seq[23] = 8'h06; seq[24] = 8'h03;
        seq[25] = 8'hB9;

        //            st cnt gp  ew  datain busy done sent
        tbl[0]  = mk(1, 5, 0,   0, 8'h01, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,   1, 8'h01, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0,   1, 8'hB8, 1, 0, 1);
        tbl[3]  = mk(0, 0, 0,   1, 8'h5C, 1, 0, 2);
        tbl[4]  = mk(0, 0, 0,   1, 8'h2E, 1, 0, 3);
        tbl[5]  = mk(0, 0, 0,   1, 8'h17, 1, 0, 4);
        tbl[6]  = mk(0, 0, 0,   0, 8'hB3, 0, 1, 5);
        tbl[7]  = mk(0, 0, 0,   0, 8'hB3, 0, 0, 5);
        tbl[8]  = mk(1, 3, 2,   0, 8'hB3, 0, 0, 5);
        tbl[9]  = mk(0, 0, 0,   1, 8'hB3, 1, 0, 0);
        tbl[10] = mk(0, 0, 0,   0, 8'hE1, 1, 0, 1);
        tbl[11] = mk(0, 0, 0,   0, 8'hE1, 1, 0, 1);
        tbl[12] = mk(0, 0, 0,   1, 8'hE1, 1, 0, 1);
        tbl[13] = mk(0, 0, 0,   0, 8'hC8, 1, 0, 2);
        tbl[14] = mk(0, 0, 0,   0, 8'hC8, 1, 0, 2);
        tbl[15] = mk(0, 0, 0,   1, 8'hC8, 1, 0, 2);
        tbl[16] = mk(0, 0, 0,   0, 8'h64, 0, 1, 3);
        tbl[17] = mk(0, 0, 0,   0, 8'h64, 0, 0, 3);

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.full  = 1'b0;
        bus.count = '0;
        bus.gap   = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.write", 32'(bus.write), 0);
        chk("rst.datain", 32'(bus.datain), 32'h01);
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.done", 32'(bus.done), 0);
        chk("rst.sent", 32'(bus.sent), 0);
`ifdef LFSR_WRITER_CSUM_EN
        chk("rst.csum", 32'(bus.csum), 0);
`endif
        step();
        rst_n = 1'b1;

        // Scenarios 1 and 2: one vector per clock cycle.
        for (int i = 0; i < NV; i++) begin
            bus.start = tbl[i].st;
            bus.count = tbl[i].cnt;
            bus.gap   = tbl[i].gp;
            @(negedge clk);
            chk($sformatf("v%0d.write", i), 32'(bus.write), 32'(tbl[i].ew));
            chk($sformatf("v%0d.datain", i), 32'(bus.datain), 32'(tbl[i].ed));
            chk($sformatf("v%0d.busy", i), 32'(bus.busy), 32'(tbl[i].eb));
            chk($sformatf("v%0d.done", i), 32'(bus.done), 32'(tbl[i].edn));
            chk($sformatf("v%0d.sent", i), 32'(bus.sent), 32'(tbl[i].es));
`ifdef LFSR_WRITER_CSUM_EN
            if (i == 7)  chk("s1.csum", 32'(bus.csum), 32'h015A);
            if (i == 17) chk("s2.csum", 32'(bus.csum), 32'h025C);
`endif
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;

        // Scenario 3: full held high for 6 cycles after the 2nd word.
        bus.count = 8'd4;
        bus.gap   = 4'd0;
        bus.start = 1'b1;
        step();
        bus.start    = 1'b0;
        n_acc        = 0;
        stall        = 0;
        stalled_once = 1'b0;
        got_done     = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            bus.full = (stall > 0);
            @(negedge clk);
            if (stall > 0) begin
                chk("s3.stall_write", 32'(bus.write), 0);
                chk("s3.stall_datain", 32'(bus.datain), 32'(seq[10]));
                stall--;
            end
            if (bus.write && n_acc < 16) begin
                acc[n_acc] = bus.datain;
                n_acc++;
            end
            if (bus.done) got_done = 1'b1;
            if (n_acc == 2 && !stalled_once) begin
                stall        = 6;
                stalled_once = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.full = 1'b0;
        chk("s3.done_seen", 32'(got_done), 1);
        chk("s3.n_words", 32'(n_acc), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s3.word%0d", k), 32'(acc[k]), 32'(seq[8 + k]));
        end
        @(negedge clk);
        chk("s3.sent", 32'(bus.sent), 4);
        chk("s3.busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;

        // Scenario 4: continuous run, start while busy ignored, abort after 10 words.
        bus.count = 8'd0;
        bus.gap   = 4'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_acc     = 0;
        for (int c = 0; c < 40 && n_acc < 10; c++) begin
            bus.start = (n_acc == 5);
            @(negedge clk);
            if (bus.write) begin
                chk($sformatf("s4.word%0d", n_acc), 32'(bus.datain), 32'(seq[12 + n_acc]));
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        chk("s4.n_words", 32'(n_acc), 10);
        bus.abort = 1'b1;
        @(negedge clk);
        chk("s4.abort_write", 32'(bus.write), 0);
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("s4.post_busy", 32'(bus.busy), 0);
        chk("s4.post_done", 32'(bus.done), 0);
        chk("s4.post_sent", 32'(bus.sent), 10);
        chk("s4.post_datain", 32'(bus.datain), 32'(seq[22]));
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.count = 8'd1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("s4.start_abort_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        @(negedge clk);
        chk("s4.one_write", 32'(bus.write), 1);
        chk("s4.one_datain", 32'(bus.datain), 32'(seq[22]));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("s4.one_done", 32'(bus.done), 1);
        chk("s4.one_sent", 32'(bus.sent), 1);
        chk("s4.one_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;

        // Scenario 5: reset pulse in the middle of a continuous run.
        bus.count = 8'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("s5.write", 32'(bus.write), 0);
        chk("s5.datain", 32'(bus.datain), 32'h01);
        chk("s5.busy", 32'(bus.busy), 0);
        chk("s5.done", 32'(bus.done), 0);
        chk("s5.sent", 32'(bus.sent), 0);
`ifdef LFSR_WRITER_CSUM_EN
        chk("s5.csum", 32'(bus.csum), 0);
`endif
        @(posedge clk);
        #1;
        bus.count = 8'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        @(negedge clk);
        chk("s5.first_write", 32'(bus.write), 1);
        chk("s5.first_datain", 32'(bus.datain), 32'(seq[0]));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("s5.second_datain", 32'(bus.datain), 32'(seq[1]));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("s5.run_done", 32'(bus.done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_writer.md
Name: lfsr_writer

Overview:
- Upstream stimulus stage for dcfifo, in the write-clock domain.
- Generates a pseudo-random DWIDTH-bit word stream from a Galois LFSR and drives dcfifo's datain/write port, honouring full.
- Supports bursts of a programmed word count with a programmable idle gap between writes. This replaces hand-written write pulses in FIFO and FIR-path benches.

Parameters:
- DWIDTH, 8, data/LFSR width; matches dcfifo DWIDTH.
- TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1, period 255).
- SEED, 8'h01, LFSR reset value; a value of 0 is replaced by 1.
- CWIDTH, 8, width of count and sent.
- GWIDTH, 4, width of gap.

Ports:
- wr_clk  in  1  clock, rising edge.
- areset_n  in  1  reset, synchronous, active-low, sampled on rising wr_clk.
- start  in  1  one-cycle pulse; begins a run when idle.
- abort  in  1  ends the run immediately.
- count  in  CWIDTH  words per run; 0 means continuous.
- gap  in  GWIDTH  idle cycles between accepted writes.
- full  in  1  from dcfifo.
- datain  out  DWIDTH  word to dcfifo; registered.
- write  out  1  write strobe to dcfifo.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse when a run completes.
- sent  out  CWIDTH  words accepted in the current or last run.

Behaviour:
- Reset (areset_n low at an edge):
  - state=IDLE, lfsr=SEED, datain=SEED.
  - write=0, busy=0, done=0, sent=0, gap counter=0.
- datain always equals the current lfsr register.
- LFSR step: next = lfsr>>1, XOR TAPS if lfsr[0]==1. The LFSR advances only on an accepted write.
- It persists across runs, so a new run continues the sequence; only reset reloads SEED.
- Acceptance: write = (state==SEND) & ~full, combinational from registered state. A word is accepted at an edge where write==1; on that edge lfsr advances and sent increments.
- IDLE:
  - busy=0.
  - On start: latch count and gap, clear sent, go to SEND.
- SEND:
  - full==1: stall. Hold state and datain, write=0.
  - Accepted and count!=0 and sent+1==count: go to IDLE, done=1 for the next cycle.
  - Accepted otherwise: go to GAP with gcnt=gap if gap!=0, else remain in SEND. Back-to-back writes are allowed when gap==0.
- GAP: write=0. Decrement gcnt; when gcnt==1, go to SEND.
- busy = (state!=IDLE).
- abort (any non-IDLE state): go to IDLE next edge. It has priority over acceptance in the same cycle, so write is forced to 0. No done pulse; sent is held.
- start while busy: ignored. start with abort in IDLE: abort wins, stay IDLE.
- count==0: runs until abort. sent wraps modulo 2^CWIDTH.
- full may toggle at any time; no word is dropped or duplicated.
- Reset mid-run: returns to the reset values above; the in-flight word is discarded.

Optional Feature:
- Macro: LFSR_WRITER_CSUM_EN.
- Defined: adds output csum (16 bits), reset 0, cleared on run start.
- On each accepted write, csum += zero-extended datain, modulo 2^16.
- Undefined: the port and logic are absent.

Decomposition:
- Package lfsr_writer_pkg holds:
  - state enum {IDLE, SEND, GAP};
  - constants DEF_TAPS=8'hB8 and DEF_SEED=8'h01;
  - the CSUM_W=16 width.
- Sub-module lfsr_core holds the LFSR register, reset-to-seed, and the advance input.

Test Plan:
1. Reset, then start with count=5, gap=0, full=0 -> write high for exactly 5 consecutive cycles. datain sequence is 01, B8, 5C, 2E, 17; done pulses once; sent=5; busy drops. With LFSR_WRITER_CSUM_EN, csum=0x015A.
2. count=3, gap=2 -> each write is followed by exactly 2 idle cycles, giving an accepted-write spacing of 3 cycles. Words are B3, then the next two LFSR values, continuing from scenario 1.
3. count=4, gap=0, full forced high for 6 cycles after the 2nd word -> write=0 during the stall and datain holds the 3rd word. Exactly 4 distinct words are accepted, with no repeats.
4. count=0, abort after 10 accepted words -> sent=10, no done pulse, write=0 from the abort edge. A second start with count=1 emits the 11th LFSR value.
5. areset_n low for one edge mid-run -> all outputs return to reset values. The next run's first word is SEED (01).
